mipi_rx_lane_ctrl: RTL and testbench
====================================

Name: mipi_rx_lane_ctrl

Overview:
- Sequences a set of per-lane MIPI byte aligners for one HS burst: holds them in reset during LP, releases them on HS entry, and deskews lanes whose sync bytes lock on different cycles.
- Strips the sync word, decodes the CSI packet header to get the packet length, and drops the aligners back into reset at end of packet.
- Sits between the per-lane aligners and the CSI packet decoder.

Parameters:
LANES, 2, number of data lanes (1, 2 or 4).
MAX_SKEW, 3, maximum lane-to-lane lock skew in clk_i cycles; larger skew is an error.

Ports:
clk_i  in  1  byte clock; all logic on rising edge.
reset_i  in  1  asynchronous, active-high reset.
hs_active_i  in  1  high while the data lanes are in HS mode.
lane_valid_i  in  LANES  byte-valid from each aligner.
lane_byte_i  in  8*LANES  aligned bytes; lane n at [8n+7:8n].
aligner_reset_o  out  1  high holds all aligners in reset.
byte_o  out  8*LANES  deskewed bytes, lane order preserved.
byte_valid_o  out  1  byte_o holds a packet word (header, payload or CRC).
packet_done_o  out  1  one-cycle pulse after the last packet word.
error_o  out  1  one-cycle pulse on skew timeout or early HS exit.

Behaviour:
- Reset values: aligner_reset_o=1, byte_o=0, byte_valid_o=0, packet_done_o=0, error_o=0; FSM in IDLE.
- IDLE: aligner_reset_o=1. Go to ARM when hs_active_i=1.
- ARM: aligner_reset_o=0.
  - Go to SKEW when any lane_valid_i bit is 1.
  - If all bits rise in the same cycle, go directly to HEADER with zero skew.
- SKEW:
  - A per-lane saturating counter counts cycles since that lane became valid.
  - When all lanes are valid: latch per-lane delay = counter value and go to HEADER.
  - If the first lane has been valid for more than MAX_SKEW cycles without all lanes valid, go to ERR.
- Deskew:
  - Each lane has a shift register of depth MAX_SKEW+1.
  - The tap equals that lane's latched delay, so the earliest lane is delayed most and the last lane has delay 0.
  - Every lane's sync byte (0xB8) lands in the same word.
- Sync word: the first deskewed word is the sync word. It is discarded and never output.
- HEADER:
  - The next 4 bytes, taken lane 0 first, are DI, WC_lo, WC_hi, ECC. They take ceil(4/LANES) words.
  - Header words are output with byte_valid_o=1.
  - Short packet when DI[5:0] < 0x10: total bytes = 4.
  - Long packet otherwise: total bytes = 4 + WC + 2. Use a 17-bit sum.
  - Total words = ceil(total bytes / LANES), loaded into a remaining-word counter.
  - Go to PAYLOAD, or to DONE if no words remain after the header.
- PAYLOAD: output one word per cycle with byte_valid_o=1 and decrement the counter. After the last word, go to DONE.
- Padding: unused bytes in the final word are passed through unmodified.
- DONE: pulse packet_done_o for one cycle, set aligner_reset_o=1, wait for hs_active_i=0, then go to IDLE.
- ERR: pulse error_o for one cycle, set aligner_reset_o=1, wait for hs_active_i=0, then go to IDLE.
- Output latency: byte_o and byte_valid_o are registered, so a word appears 1 cycle after it leaves the deskew tap.
- HS exit: hs_active_i=0 in ARM or SKEW goes to IDLE silently. In HEADER or PAYLOAD it pulses error_o, forces byte_valid_o=0 from the next cycle, and goes to IDLE.
- Lane dropout: any lane_valid_i falling in HEADER or PAYLOAD is treated as an HS exit error.
- Simultaneous events: last-word completion and hs_active_i falling in the same cycle count as a normal completion (packet_done_o, no error_o).
- Async reset asserted mid-burst returns every output to its reset value immediately.
- byte_valid_o is never high outside HEADER and PAYLOAD words.

Test Plan:
- Lock with skew 2: LANES=2, MAX_SKEW=3, hs_active_i=1, lane0 valid at cycle 5, lane1 at cycle 7; both streams are B8, then header 2A,04,00,xx, then 4 payload bytes, then 2 CRC bytes. Required: byte_valid_o high for exactly 5 consecutive cycles, first byte_o = {lane1,lane0} = 16'h042A, then packet_done_o pulses once and aligner_reset_o=1.
- Short packet: DI=0x00, WC=0x0001, all lanes lock in the same cycle. Required: exactly 2 valid words (header only), packet_done_o pulse, aligner_reset_o rises.
- Skew timeout: lane0 valid, lane1 still low after 4 cycles. Required: error_o pulses once, byte_valid_o stays 0, aligner_reset_o=1 until hs_active_i=0.
- Early HS exit: hs_active_i dropped on payload word 2 of WC=16. Required: error_o pulse, byte_valid_o=0 the next cycle, FSM in IDLE, no packet_done_o.
- Back-to-back bursts: two HS bursts separated by 3 LP cycles. Required: aligner_reset_o=1 throughout the LP gap and both packets are delivered intact.
- Async reset: reset_i pulsed during PAYLOAD. Required: all outputs at reset values with no clock edge, then normal operation on the next burst.

Source files
------------

// File: rtl/mipi_rx_lane_ctrl.sv
// MIPI CSI-2 receive lane controller: sequences the per-lane byte aligners for one
// HS burst, deskews lane lock, strips the sync word and frames a single packet.
`timescale 1ns/1ps
module mipi_rx_lane_ctrl #(
   parameter int LANES    = 2,
   parameter int MAX_SKEW = 3
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               hs_active_i,
   input  logic [LANES-1:0]   lane_valid_i,
   input  logic [8*LANES-1:0] lane_byte_i,
   output logic               aligner_reset_o,
   output logic [8*LANES-1:0] byte_o,
   output logic               byte_valid_o,
   output logic               packet_done_o,
   output logic               error_o
);

   localparam int W         = 8 * LANES;
   localparam int CW        = $clog2(MAX_SKEW + 2);
   localparam int HDR_WORDS = (4 + LANES - 1) / LANES;
   localparam int HW        = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

   localparam logic [CW-1:0] CNT_MAX      = CW'(MAX_SKEW);
   localparam logic [CW-1:0] CNT_SAT      = CW'(MAX_SKEW + 1);
   localparam logic [HW-1:0] HDR_LAST     = HW'(HDR_WORDS - 1);
   localparam logic [16:0]   HDR_WORDS_17 = 17'(HDR_WORDS);
   localparam logic [16:0]   LANES_M1_17  = 17'(LANES - 1);
   localparam logic [16:0]   LANES_17     = 17'(LANES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_SKEW    = 3'd2,
      S_HEADER  = 3'd3,
      S_PAYLOAD = 3'd4,
      S_DONE    = 3'd5,
      S_ERR     = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q   [LANES];
   logic [CW-1:0]   cnt_d   [LANES];
   logic [CW-1:0]   delay_q [LANES];
   logic [CW-1:0]   delay_d [LANES];
   logic [7:0]      hist_q  [LANES][MAX_SKEW];
   logic [7:0]      hist_d  [LANES][MAX_SKEW];
   logic [23:0]     hdr_q, hdr_d;
   logic [HW-1:0]   hdr_idx_q, hdr_idx_d;
   logic [16:0]     rem_q, rem_d;
   logic [W-1:0]    byte_q, byte_d;
   logic            byte_valid_q, byte_valid_d;
   logic            last_q, last_d;
   logic            packet_done_q;
   logic            error_q, error_d;
   logic            aligner_reset_q, aligner_reset_d;

   logic [W-1:0]    word_s;
   logic [23:0]     hdr_s;
   logic [16:0]     total_bytes_s, total_words_s, rem_load_s;
   logic            all_valid_s, any_valid_s, timeout_s, lane_loss_s, hdr_last_s;

   // Deskew taps, lane history shift, and running header decode (DI, WC_lo, WC_hi).
   always_comb begin
      word_s = {W{1'b0}};
      hdr_s  = hdr_q;
      for (int n = 0; n < LANES; n++) begin
         word_s[8*n +: 8] = lane_byte_i[8*n +: 8];
         for (int k = 0; k < MAX_SKEW; k++) begin
            word_s[8*n +: 8] = (delay_q[n] == CW'(k + 1)) ? hist_q[n][k] : word_s[8*n +: 8];
         end
         hist_d[n][0] = lane_byte_i[8*n +: 8];
         for (int k = 1; k < MAX_SKEW; k++) begin
            hist_d[n][k] = hist_q[n][k-1];
         end
      end
      for (int b = 0; b < 3; b++) begin
         hdr_s[8*b +: 8] = (hdr_idx_q == HW'(b / LANES)) ? word_s[8*(b % LANES) +: 8]
                                                          : hdr_s[8*b +: 8];
      end
      total_bytes_s = (hdr_s[5:0] < 6'h10) ? 17'd4 : (17'd6 + {1'b0, hdr_s[23:8]});
      total_words_s = (total_bytes_s + LANES_M1_17) / LANES_17;
      rem_load_s    = total_words_s - HDR_WORDS_17;
      hdr_last_s    = (hdr_idx_q == HDR_LAST);
      all_valid_s   = &lane_valid_i;
      any_valid_s   = |lane_valid_i;
      lane_loss_s   = ~all_valid_s;
      timeout_s     = 1'b0;
      for (int n = 0; n < LANES; n++) begin
         timeout_s = timeout_s | (cnt_q[n] > CNT_MAX);
      end
   end

   // Burst sequencing FSM: next state, lock counters and registered output values.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      delay_d      = delay_q;
      hdr_d        = hdr_q;
      hdr_idx_d    = hdr_idx_q;
      rem_d        = rem_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      last_d       = 1'b0;
      error_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            hdr_idx_d = {HW{1'b0}};
            for (int n = 0; n < LANES; n++) begin
               cnt_d[n] = {CW{1'b0}};
            end
            if (hs_active_i) begin
               state_d = S_ARM;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ARM: begin
            if (!hs_active_i) begin
               state_d = S_IDLE;
            end else if (all_valid_s) begin
               for (int n = 0; n < LANES; n++) begin
                  delay_d[n] = {CW{1'b0}};
               end
               state_d = S_HEADER;
            end else if (any_valid_s) begin
               for (int n = 0; n < LANES; n++) begin
                  cnt_d[n] = lane_valid_i[n] ? CW'(1) : CW'(0);
               end
               state_d = S_SKEW;
            end else begin
               state_d = S_ARM;
            end
         end
         S_SKEW: begin
            for (int n = 0; n < LANES; n++) begin
               cnt_d[n] = !lane_valid_i[n] ? CW'(0) :
                          (cnt_q[n] == CNT_SAT) ? CNT_SAT : cnt_q[n] + CW'(1);
            end
            if (!hs_active_i) begin
               state_d = S_IDLE;
            end else if (timeout_s) begin
               error_d = 1'b1;
               state_d = S_ERR;
            end else if (all_valid_s) begin
               delay_d = cnt_q;
               state_d = S_HEADER;
            end else begin
               state_d = S_SKEW;
            end
         end
         S_HEADER: begin
            if (hdr_last_s && (rem_load_s == 17'd0)) begin
               byte_d       = word_s;
               byte_valid_d = 1'b1;
               last_d       = 1'b1;
               state_d      = S_DONE;
            end else if (!hs_active_i || lane_loss_s) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               byte_d       = word_s;
               byte_valid_d = 1'b1;
               hdr_d        = hdr_s;
               if (hdr_last_s) begin
                  rem_d   = rem_load_s;
                  state_d = S_PAYLOAD;
               end else begin
                  hdr_idx_d = hdr_idx_q + HW'(1);
               end
            end
         end
         S_PAYLOAD: begin
            // The final word wins over a simultaneous HS exit.
            if (rem_q == 17'd1) begin
               byte_d       = word_s;
               byte_valid_d = 1'b1;
               last_d       = 1'b1;
               state_d      = S_DONE;
            end else if (!hs_active_i || lane_loss_s) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               byte_d       = word_s;
               byte_valid_d = 1'b1;
               rem_d        = rem_q - 17'd1;
            end
         end
         S_DONE, S_ERR: begin
            if (!hs_active_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      aligner_reset_d = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR);
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q         <= S_IDLE;
         hdr_q           <= 24'h000000;
         hdr_idx_q       <= {HW{1'b0}};
         rem_q           <= 17'd0;
         byte_q          <= {W{1'b0}};
         byte_valid_q    <= 1'b0;
         last_q          <= 1'b0;
         packet_done_q   <= 1'b0;
         error_q         <= 1'b0;
         aligner_reset_q <= 1'b1;
         for (int n = 0; n < LANES; n++) begin
            cnt_q[n]   <= {CW{1'b0}};
            delay_q[n] <= {CW{1'b0}};
            for (int k = 0; k < MAX_SKEW; k++) begin
               hist_q[n][k] <= 8'h00;
            end
         end
      end else begin
         state_q         <= state_d;
         hdr_q           <= hdr_d;
         hdr_idx_q       <= hdr_idx_d;
         rem_q           <= rem_d;
         byte_q          <= byte_d;
         byte_valid_q    <= byte_valid_d;
         last_q          <= last_d;
         packet_done_q   <= last_q;
         error_q         <= error_d;
         aligner_reset_q <= aligner_reset_d;
         cnt_q           <= cnt_d;
         delay_q         <= delay_d;
         hist_q          <= hist_d;
      end
   end

   assign aligner_reset_o = aligner_reset_q;
   assign byte_o          = byte_q;
   assign byte_valid_o    = byte_valid_q;
   assign packet_done_o   = packet_done_q;
   assign error_o         = error_q;

endmodule

// File: tb/tb_mipi_rx_lane_ctrl.sv
// Directed testbench for mipi_rx_lane_ctrl with LANES=2, MAX_SKEW=3.
`timescale 1ns/1ps
module tb_mipi_rx_lane_ctrl;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        hs_active_i;
   logic [1:0]  lane_valid_i;
   logic [15:0] lane_byte_i;
   logic        aligner_reset_o;
   logic [15:0] byte_o;
   logic        byte_valid_o;
   logic        packet_done_o;
   logic        error_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  s0[$];
   logic [7:0]  s1[$];
   logic [15:0] cap_q[$];
   int   runs, done_cnt, err_cnt, ar_lp_bad, ar_after_err_bad;
   logic prev_bv, ar_at_done, ar_at_err, bv_at_err, ar_first_valid;

   mipi_rx_lane_ctrl #(.LANES(2), .MAX_SKEW(3)) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .hs_active_i     (hs_active_i),
      .lane_valid_i    (lane_valid_i),
      .lane_byte_i     (lane_byte_i),
      .aligner_reset_o (aligner_reset_o),
      .byte_o          (byte_o),
      .byte_valid_o    (byte_valid_o),
      .packet_done_o   (packet_done_o),
      .error_o         (error_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_score();
      cap_q.delete();
      runs = 0; done_cnt = 0; err_cnt = 0; ar_lp_bad = 0; ar_after_err_bad = 0;
      prev_bv = 1'b0; ar_at_done = 1'b0; ar_at_err = 1'b0; bv_at_err = 1'b0;
      ar_first_valid = 1'b1;
   endtask

   // Drives one burst cycle by cycle (called at a falling edge) and records outputs.
   task automatic run_burst(input int ncyc, input int hs_on, input int hs_off,
                            input int st0, input int st1);
      for (int c = 0; c < ncyc; c++) begin
         logic hs;
         hs = (c >= hs_on) && (c < hs_off);
         hs_active_i       = hs;
         lane_valid_i[0]   = hs && (c >= st0);
         lane_valid_i[1]   = hs && (c >= st1);
         lane_byte_i[7:0]  = (c >= st0 && (c - st0) < s0.size()) ? s0[c - st0] : 8'h00;
         lane_byte_i[15:8] = (c >= st1 && (c - st1) < s1.size()) ? s1[c - st1] : 8'h00;
         @(posedge clk_i);
         @(negedge clk_i);
         if (byte_valid_o) begin
            cap_q.push_back(byte_o);
            if (cap_q.size() == 1) ar_first_valid = aligner_reset_o;
         end
         if (byte_valid_o && !prev_bv) runs++;
         prev_bv = byte_valid_o;
         if (packet_done_o) begin done_cnt++; ar_at_done = aligner_reset_o; end
         if (error_o) begin err_cnt++; ar_at_err = aligner_reset_o; bv_at_err = byte_valid_o; end
         if (!hs && !aligner_reset_o) ar_lp_bad++;
         if (err_cnt > 0 && !error_o && hs && !aligner_reset_o) ar_after_err_bad++;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1; hs_active_i = 1'b0; lane_valid_i = 2'b00; lane_byte_i = 16'h0000;
      #12;
      n_checks++; if (aligner_reset_o !== 1'b1) begin n_fail++; $display("FAIL reset_aligner_reset got %b want 1", aligner_reset_o); end
      n_checks++; if (byte_o !== 16'h0000) begin n_fail++; $display("FAIL reset_byte got %h want 0000", byte_o); end
      n_checks++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid got %b want 0", byte_valid_o); end
      n_checks++; if (packet_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", packet_done_o); end
      n_checks++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error_o); end
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic load_skew_packet();
      s0 = '{8'hB8, 8'h2A, 8'h00, 8'h11, 8'h33, 8'hC0};
      s1 = '{8'hB8, 8'h04, 8'hE5, 8'h22, 8'h44, 8'hC1};
   endtask

   task automatic load_short_packet();
      s0 = '{8'hB8, 8'h00, 8'h00};
      s1 = '{8'hB8, 8'h01, 8'h7F};
   endtask

   task automatic load_long_packet();
      s0 = '{8'hB8, 8'h2A, 8'h00, 8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D, 8'h0F, 8'hC0};
      s1 = '{8'hB8, 8'h10, 8'h3C, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'hC1};
   endtask

   task automatic test_skew_lock();
      logic [15:0] exp_w [5];
      logic [15:0] got;
      exp_w = '{16'h042A, 16'hE500, 16'h2211, 16'h4433, 16'hC1C0};
      clear_score();
      load_skew_packet();
      run_burst(24, 1, 20, 5, 7);
      n_checks++; if (cap_q.size() != 5) begin n_fail++; $display("FAIL skew_word_count got %0d want 5", cap_q.size()); end
      for (int i = 0; i < 5; i++) begin
         got = (i < cap_q.size()) ? cap_q[i] : 16'hxxxx;
         n_checks++; if (got !== exp_w[i]) begin n_fail++; $display("FAIL skew_word%0d got %h want %h", i, got, exp_w[i]); end
      end
      n_checks++; if (runs != 1) begin n_fail++; $display("FAIL skew_valid_runs got %0d want 1", runs); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL skew_done_pulses got %0d want 1", done_cnt); end
      n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL skew_errors got %0d want 0", err_cnt); end
      n_checks++; if (ar_at_done !== 1'b1) begin n_fail++; $display("FAIL skew_aligner_reset_at_done got %b want 1", ar_at_done); end
      n_checks++; if (ar_first_valid !== 1'b0) begin n_fail++; $display("FAIL skew_aligner_reset_in_packet got %b want 0", ar_first_valid); end
   endtask

   task automatic test_short_packet();
      clear_score();
      load_short_packet();
      run_burst(12, 1, 10, 4, 4);
      n_checks++; if (cap_q.size() != 2) begin n_fail++; $display("FAIL short_word_count got %0d want 2", cap_q.size()); end
      n_checks++; if (cap_q.size() > 0 && cap_q[0] !== 16'h0100) begin n_fail++; $display("FAIL short_word0 got %h want 0100", cap_q[0]); end
      n_checks++; if (cap_q.size() > 1 && cap_q[1] !== 16'h7F00) begin n_fail++; $display("FAIL short_word1 got %h want 7f00", cap_q[1]); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL short_done_pulses got %0d want 1", done_cnt); end
      n_checks++; if (ar_at_done !== 1'b1) begin n_fail++; $display("FAIL short_aligner_reset got %b want 1", ar_at_done); end
   endtask

   task automatic test_skew_timeout();
      clear_score();
      load_skew_packet();
      run_burst(20, 1, 15, 5, 99);
      n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL timeout_error_pulses got %0d want 1", err_cnt); end
      n_checks++; if (cap_q.size() != 0) begin n_fail++; $display("FAIL timeout_valid_words got %0d want 0", cap_q.size()); end
      n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL timeout_done_pulses got %0d want 0", done_cnt); end
      n_checks++; if (ar_at_err !== 1'b1) begin n_fail++; $display("FAIL timeout_aligner_reset got %b want 1", ar_at_err); end
      n_checks++; if (ar_after_err_bad != 0) begin n_fail++; $display("FAIL timeout_aligner_released got %0d want 0", ar_after_err_bad); end
   endtask

   task automatic test_early_exit();
      clear_score();
      load_long_packet();
      run_burst(12, 1, 8, 4, 4);
      n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL exit_error_pulses got %0d want 1", err_cnt); end
      n_checks++; if (bv_at_err !== 1'b0) begin n_fail++; $display("FAIL exit_valid_after got %b want 0", bv_at_err); end
      n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL exit_done_pulses got %0d want 0", done_cnt); end
      n_checks++; if (ar_at_err !== 1'b1) begin n_fail++; $display("FAIL exit_aligner_reset got %b want 1", ar_at_err); end
      n_checks++; if (cap_q.size() != 3) begin n_fail++; $display("FAIL exit_word_count got %0d want 3", cap_q.size()); end
      n_checks++; if (cap_q.size() > 2 && cap_q[2] !== 16'h0201) begin n_fail++; $display("FAIL exit_payload1 got %h want 0201", cap_q[2]); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_w [7];
      logic [15:0] got;
      exp_w = '{16'h0100, 16'h7F00, 16'h042A, 16'hE500, 16'h2211, 16'h4433, 16'hC1C0};
      clear_score();
      load_short_packet();
      run_burst(12, 1, 10, 4, 4);
      load_skew_packet();
      run_burst(24, 1, 20, 5, 7);
      n_checks++; if (cap_q.size() != 7) begin n_fail++; $display("FAIL b2b_word_count got %0d want 7", cap_q.size()); end
      for (int i = 0; i < 7; i++) begin
         got = (i < cap_q.size()) ? cap_q[i] : 16'hxxxx;
         n_checks++; if (got !== exp_w[i]) begin n_fail++; $display("FAIL b2b_word%0d got %h want %h", i, got, exp_w[i]); end
      end
      n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_pulses got %0d want 2", done_cnt); end
      n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL b2b_errors got %0d want 0", err_cnt); end
      n_checks++; if (ar_lp_bad != 0) begin n_fail++; $display("FAIL b2b_aligner_reset_in_lp got %0d want 0", ar_lp_bad); end
   endtask

   task automatic test_async_reset();
      clear_score();
      load_long_packet();
      run_burst(8, 1, 100, 4, 4);
      n_checks++; if (byte_valid_o !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid got %b want 1", byte_valid_o); end
      n_checks++; if (byte_o !== 16'h0201) begin n_fail++; $display("FAIL areset_pre_byte got %h want 0201", byte_o); end
      #2 reset_i = 1'b1;
      #1;
      n_checks++; if (aligner_reset_o !== 1'b1) begin n_fail++; $display("FAIL areset_aligner_reset got %b want 1", aligner_reset_o); end
      n_checks++; if (byte_o !== 16'h0000) begin n_fail++; $display("FAIL areset_byte got %h want 0000", byte_o); end
      n_checks++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_byte_valid got %b want 0", byte_valid_o); end
      n_checks++; if (packet_done_o !== 1'b0) begin n_fail++; $display("FAIL areset_done got %b want 0", packet_done_o); end
      n_checks++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL areset_error got %b want 0", error_o); end
      hs_active_i = 1'b0; lane_valid_i = 2'b00; lane_byte_i = 16'h0000;
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      clear_score();
      load_short_packet();
      run_burst(12, 1, 10, 4, 4);
      n_checks++; if (cap_q.size() != 2) begin n_fail++; $display("FAIL areset_after_word_count got %0d want 2", cap_q.size()); end
      n_checks++; if (cap_q.size() > 0 && cap_q[0] !== 16'h0100) begin n_fail++; $display("FAIL areset_after_word0 got %h want 0100", cap_q[0]); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL areset_after_done got %0d want 1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_skew_lock();
      test_short_packet();
      test_skew_timeout();
      test_early_exit();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
